// File: rtl/hazard_ctrl.sv
// hazard_ctrl: decode-stage hazard controller (load-use stall, branch flush, multi-cycle EX freeze).
// Ports: clk/rst (sync, active-high); ifidRs1/ifidRs2/idexRd/idexMemRead feed load-use detection;
// exBranchTaken/exMcStart come from EX; pcWrite/ifidWrite/ifidFlush/idexBubble/idexHold steer the
// pipeline registers; mcDone marks the last freeze cycle; busy = MC_BUSY. Define HAZARD_STATS_EN
// to add saturating stallCycles/flushCount counter outputs.
module hazard_ctrl #(
    parameter int unsigned MC_LATENCY = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] ifidRs1,
    input  logic [4:0] ifidRs2,
    input  logic [4:0] idexRd,
    input  logic       idexMemRead,
    input  logic       exBranchTaken,
    input  logic       exMcStart,
    output logic       pcWrite,
    output logic       ifidWrite,
    output logic       ifidFlush,
    output logic       idexBubble,
    output logic       idexHold,
    output logic       mcDone,
    output logic       busy
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0] stallCycles,
    output logic [15:0] flushCount
`endif
);
    typedef enum logic {RUN, MC_BUSY} state_t;
    localparam logic [7:0] MC_LAT = 8'(MC_LATENCY);
    state_t     state_q, state_d;
    logic [7:0] mc_cnt_q, mc_cnt_d;
    logic       lu_haz;
    assign lu_haz = idexMemRead && (idexRd != 5'd0) && (idexRd == ifidRs1 || idexRd == ifidRs2);
    always_comb begin
        state_d    = state_q;
        mc_cnt_d   = mc_cnt_q;
        pcWrite    = 1'b1;
        ifidWrite  = 1'b1;
        ifidFlush  = 1'b0;
        idexBubble = 1'b0;
        idexHold   = 1'b0;
        mcDone     = 1'b0;
        busy       = 1'b0;
        if (rst) begin
            pcWrite    = 1'b0;
            ifidWrite  = 1'b0;
            idexBubble = 1'b1;
        end else if (state_q == MC_BUSY) begin
            pcWrite   = 1'b0;
            ifidWrite = 1'b0;
            idexHold  = 1'b1;
            busy      = 1'b1;
            mc_cnt_d  = mc_cnt_q - 8'd1;
            if (mc_cnt_q == 8'd1) begin
                mcDone  = 1'b1;
                state_d = RUN;
            end
        end else if (exMcStart) begin
            pcWrite   = 1'b0;
            ifidWrite = 1'b0;
            idexHold  = 1'b1;
            // A one-cycle op completes in its start cycle, so it never enters MC_BUSY.
            if (MC_LATENCY == 1) begin
                mcDone = 1'b1;
            end else begin
                mc_cnt_d = MC_LAT - 8'd1;
                state_d  = MC_BUSY;
            end
        end else if (exBranchTaken) begin
            ifidFlush  = 1'b1;
            idexBubble = 1'b1;
        end else if (lu_haz) begin
            // The bubble removes the load from ID/EX, so the hazard self-clears next cycle.
            pcWrite    = 1'b0;
            ifidWrite  = 1'b0;
            idexBubble = 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RUN;
            mc_cnt_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            mc_cnt_q <= mc_cnt_d;
        end
    end
`ifdef HAZARD_STATS_EN
    logic [15:0] stall_q, flush_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= 16'd0;
            flush_q <= 16'd0;
        end else begin
            if (!pcWrite && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
            if (ifidFlush && flush_q != 16'hFFFF) flush_q <= flush_q + 16'd1;
        end
    end
    assign stallCycles = stall_q;
    assign flushCount  = flush_q;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: randomized and directed checks of hazard_ctrl against a cycle-level reference model.
module tb_hazard_ctrl;
    localparam int LAT = 4;
    logic       clk;
    logic       rst;
    logic [4:0] ifidRs1, ifidRs2, idexRd;
    logic       idexMemRead, exBranchTaken, exMcStart;
    logic       pc_w, ifid_w, ifid_f, idex_b, idex_h, mc_done, busy;
    logic       pc_w1, ifid_w1, ifid_f1, idex_b1, idex_h1, mc_done1, busy1;
    logic [6:0] outs, outs1, e;
    int         checks = 0;
    int         errors = 0;
    int         rem = 0;
`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cnt, flush_cnt, stall_cnt1, flush_cnt1;
    int          exp_stall = 0;
    int          exp_flush = 0;
`endif

    hazard_ctrl #(.MC_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .ifidRs1(ifidRs1), .ifidRs2(ifidRs2), .idexRd(idexRd),
        .idexMemRead(idexMemRead), .exBranchTaken(exBranchTaken), .exMcStart(exMcStart),
        .pcWrite(pc_w), .ifidWrite(ifid_w), .ifidFlush(ifid_f), .idexBubble(idex_b),
        .idexHold(idex_h), .mcDone(mc_done), .busy(busy)
`ifdef HAZARD_STATS_EN
        , .stallCycles(stall_cnt), .flushCount(flush_cnt)
`endif
    );

    hazard_ctrl #(.MC_LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .ifidRs1(ifidRs1), .ifidRs2(ifidRs2), .idexRd(idexRd),
        .idexMemRead(idexMemRead), .exBranchTaken(exBranchTaken), .exMcStart(exMcStart),
        .pcWrite(pc_w1), .ifidWrite(ifid_w1), .ifidFlush(ifid_f1), .idexBubble(idex_b1),
        .idexHold(idex_h1), .mcDone(mc_done1), .busy(busy1)
`ifdef HAZARD_STATS_EN
        , .stallCycles(stall_cnt1), .flushCount(flush_cnt1)
`endif
    );

    assign outs  = {pc_w, ifid_w, ifid_f, idex_b, idex_h, mc_done, busy};
    assign outs1 = {pc_w1, ifid_w1, ifid_f1, idex_b1, idex_h1, mc_done1, busy1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {pcWrite, ifidWrite, ifidFlush, idexBubble, idexHold, mcDone, busy}
    // given `r` freeze cycles still owed by an op started earlier.
    function automatic logic [6:0] model(input int lat, input int r);
        logic lu;
        lu = idexMemRead && idexRd != 0 && (idexRd == ifidRs1 || idexRd == ifidRs2);
        if (rst) return 7'b0001000;
        if (r > 0) return {5'b00001, r == 1, 1'b1};
        if (exMcStart) return {5'b00001, lat == 1, 1'b0};
        if (exBranchTaken) return 7'b1111000;
        if (lu) return 7'b0001000;
        return 7'b1100000;
    endfunction

    task automatic advance();
        logic [6:0] m;
        m = model(LAT, rem);
`ifdef HAZARD_STATS_EN
        if (rst) begin
            exp_stall = 0;
            exp_flush = 0;
        end else begin
            if (!m[6] && exp_stall < 65535) exp_stall++;
            if (m[4] && exp_flush < 65535) exp_flush++;
        end
`endif
        @(posedge clk);
        if (rst) rem = 0;
        else if (rem > 0) rem = rem - 1;
        else if (exMcStart) rem = LAT - 1;
        #1;
    endtask

    task automatic quiet();
        rst = 0; idexMemRead = 0; exBranchTaken = 0; exMcStart = 0;
        ifidRs1 = 5'd1; ifidRs2 = 5'd2; idexRd = 5'd3;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            rst = 1; exMcStart = 1'($urandom); exBranchTaken = 1'($urandom); idexMemRead = 1;
            idexRd = 5'd7; ifidRs1 = 5'd7; ifidRs2 = 5'($urandom);
            @(negedge clk);
            checks++;
            if (outs !== 7'b0001000) begin
                errors++;
                $display("FAIL reset cycle %0d: got %b want %b", i, outs, 7'b0001000);
            end
            advance();
        end
        quiet();
    endtask

    task automatic test_load_use();
        quiet(); idexMemRead = 1; idexRd = 5'd5; ifidRs2 = 5'd5; ifidRs1 = 5'd9;
        @(negedge clk);
        checks++;
        if (outs !== 7'b0001000) begin
            errors++;
            $display("FAIL load_use stall: got %b want %b", outs, 7'b0001000);
        end
        advance();
        idexMemRead = 0;
        @(negedge clk);
        checks++;
        if (outs !== 7'b1100000) begin
            errors++;
            $display("FAIL load_use release: got %b want %b", outs, 7'b1100000);
        end
        advance();
    endtask

    task automatic test_x0();
        quiet(); idexMemRead = 1; idexRd = 5'd0; ifidRs1 = 5'd0; ifidRs2 = 5'd0;
        @(negedge clk);
        checks++;
        if (outs !== 7'b1100000) begin
            errors++;
            $display("FAIL x0_exempt: got %b want %b", outs, 7'b1100000);
        end
        advance();
        quiet();
    endtask

    task automatic test_branch_vs_lu();
`ifdef HAZARD_STATS_EN
        logic [15:0] f0;
        f0 = flush_cnt;
`endif
        quiet(); idexMemRead = 1; idexRd = 5'd12; ifidRs1 = 5'd12; exBranchTaken = 1;
        @(negedge clk);
        checks++;
        if (outs !== 7'b1111000) begin
            errors++;
            $display("FAIL branch_beats_lu: got %b want %b", outs, 7'b1111000);
        end
        advance();
        quiet();
`ifdef HAZARD_STATS_EN
        @(negedge clk);
        checks++;
        if (flush_cnt !== f0 + 16'd1) begin
            errors++;
            $display("FAIL flush_count: got %0d want %0d", flush_cnt, f0 + 16'd1);
        end
`endif
    endtask

    task automatic test_multicycle();
        logic [6:0] want [5];
        want = '{7'b0000100, 7'b0000101, 7'b0000101, 7'b0000111, 7'b1100000};
        quiet();
        for (int k = 0; k < 5; k++) begin
            exMcStart = (k == 0);
            exBranchTaken = (k == 2);
            idexMemRead = (k == 3); idexRd = 5'd1;
            @(negedge clk);
            checks++;
            if (outs !== want[k] || outs !== model(LAT, rem)) begin
                errors++;
                $display("FAIL multicycle N+%0d: got %b want %b", k, outs, want[k]);
            end
            if (k < 4) advance();
        end
        quiet();
        advance();
    endtask

    task automatic test_mc_latency1();
        quiet(); exMcStart = 1;
        @(negedge clk);
        checks++;
        if (outs1 !== 7'b0000110) begin
            errors++;
            $display("FAIL lat1 start: got %b want %b", outs1, 7'b0000110);
        end
        advance();
        exMcStart = 0;
        for (int k = 0; k < LAT; k++) begin
            @(negedge clk);
            checks++;
            if (outs1 !== 7'b1100000 || outs !== model(LAT, rem)) begin
                errors++;
                $display("FAIL lat1 after %0d: got %b/%b want %b/%b", k, outs1, outs, 7'b1100000, model(LAT, rem));
            end
            advance();
        end
    endtask

    task automatic test_reset_mid_op();
        quiet(); exMcStart = 1;
        advance();
        exMcStart = 0; rst = 1;
        @(negedge clk);
        checks++;
        if (outs !== 7'b0001000) begin
            errors++;
            $display("FAIL reset_mid_op during: got %b want %b", outs, 7'b0001000);
        end
        advance();
        rst = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (outs !== 7'b1100000) begin
                errors++;
                $display("FAIL reset_mid_op after %0d: got %b want %b", k, outs, 7'b1100000);
            end
            advance();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            exMcStart = ($urandom_range(0, 14) == 0);
            exBranchTaken = ($urandom_range(0, 5) == 0);
            idexMemRead = 1'($urandom);
            idexRd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            ifidRs1 = $urandom_range(0, 2) == 0 ? idexRd : 5'($urandom);
            ifidRs2 = $urandom_range(0, 2) == 0 ? idexRd : 5'($urandom);
            @(negedge clk);
            e = model(LAT, rem);
            checks++;
            if (outs !== e || (idex_h && idex_b) || (ifid_f && !ifid_w)) begin
                errors++;
                $display("FAIL random cycle %0d: got %b want %b", i, outs, e);
            end
            advance();
        end
        quiet();
`ifdef HAZARD_STATS_EN
        @(negedge clk);
        checks++;
        if (stall_cnt !== 16'(exp_stall) || flush_cnt !== 16'(exp_flush)) begin
            errors++;
            $display("FAIL stats: got %0d/%0d want %0d/%0d", stall_cnt, flush_cnt, exp_stall, exp_flush);
        end
`endif
    endtask

    initial begin
        rst = 1; idexMemRead = 0; exBranchTaken = 0; exMcStart = 0;
        ifidRs1 = 0; ifidRs2 = 0; idexRd = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_load_use();
        test_x0();
        test_branch_vs_lu();
        test_multicycle();
        test_mc_latency1();
        test_reset_mid_op();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the decode stage: it decides each cycle whether fetch and IF/ID advance, whether ID/EX receives a bubble or holds, and whether IF/ID is flushed. It covers three cases:
- load-use data hazards, detected between IF/ID and ID/EX;
- taken-branch flushes, signalled from EX;
- multi-cycle EX operations, which freeze the front of the pipe for a fixed latency.

It sits beside stage 2 and drives the write enables of the stage 1 PC, the IF/ID register and the ID/EX register.

## Interface
Parameters:
- MC_LATENCY, default 4: total stall cycles for a multi-cycle EX op, counting the start cycle. Legal range 1..255.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  clock; every register updates on the posedge.
- rst  in  1  synchronous reset, active-high.
- ifidRs1  in  5  rs1 field (inst[19:15]) of the instruction in IF/ID.
- ifidRs2  in  5  rs2 field (inst[24:20]) of the instruction in IF/ID.
- idexRd  in  5  destination register held in ID/EX.
- idexMemRead  in  1  the ID/EX instruction is a load (from idexMemCtrl).
- exBranchTaken  in  1  EX resolved a taken branch or jump this cycle.
- exMcStart  in  1  EX begins a multi-cycle op this cycle (single-cycle pulse).
- pcWrite  out  1  1 = PC may update.
- ifidWrite  out  1  1 = IF/ID may load.
- ifidFlush  out  1  1 = IF/ID loads a NOP (0x00000013).
- idexBubble  out  1  1 = ID/EX loads all-zero Ex/Mem/Wb control fields.
- idexHold  out  1  1 = ID/EX keeps its current contents.
- mcDone  out  1  pulse on the final stall cycle of a multi-cycle op.
- busy  out  1  state == MC_BUSY.

## Operation
- State machine: two states, RUN and MC_BUSY. There is also a countdown register mcCnt, 8 bits wide.
- All outputs are combinational from the current state and the current inputs (Mealy).
- Load-use hazard: luHaz = idexMemRead & (idexRd != 0) & (idexRd == ifidRs1 | idexRd == ifidRs2). rs fields are compared for every opcode; a false stall on an unused field is accepted.
- In RUN, exactly one case applies, in priority order:
  1. exMcStart: freeze. pcWrite=0, ifidWrite=0, idexHold=1, idexBubble=0, ifidFlush=0. If MC_LATENCY==1, mcDone=1 and the state stays RUN. Otherwise mcCnt <= MC_LATENCY-1 and the state goes to MC_BUSY.
  2. exBranchTaken: flush. pcWrite=1, ifidWrite=1, ifidFlush=1, idexBubble=1. This takes effect even if luHaz=1.
  3. luHaz: stall. pcWrite=0, ifidWrite=0, idexBubble=1, idexHold=0. The bubble clears the hazard on the next cycle, so no extra state is needed.
  4. Otherwise: normal flow. pcWrite=1, ifidWrite=1, all other outputs 0.
- In MC_BUSY:
  - Freeze outputs, as in case 1.
  - mcCnt decrements every cycle.
  - When mcCnt==1: mcDone=1 and the next state is RUN.
  - exBranchTaken, exMcStart and luHaz are ignored in this state, because EX is held.
- exMcStart together with exBranchTaken is illegal. If it occurs, exMcStart wins.
- Invariants:
  - idexHold and idexBubble are never both 1.
  - ifidFlush=1 implies ifidWrite=1.

## Timing
- While rst=1, outputs are forced to: pcWrite=0, ifidWrite=0, ifidFlush=0, idexBubble=1, idexHold=0, mcDone=0, busy=0.
- On the clock edge with rst=1: state <= RUN, mcCnt <= 0, and stats counters <= 0.
- Reset asserted during MC_BUSY aborts the operation. mcDone is not pulsed.
- Load-use costs exactly 1 stall cycle. A taken branch costs 1 flushed IF/ID slot.
- A multi-cycle op costs exactly MC_LATENCY freeze cycles:
  - The start cycle is one of them.
  - mcDone is high only on the last of them.
  - The cycle after mcDone is a RUN cycle and evaluates its inputs normally.
- Zero-latency response: all output decisions depend only on same-cycle inputs and registered state.

## Configuration
- Macro HAZARD_STATS_EN.
- When defined, two extra output ports are added:
  - stallCycles [15:0] counts cycles with pcWrite=0 and rst=0.
  - flushCount [15:0] counts cycles with ifidFlush=1.
  - Both counters saturate at 0xFFFF and clear on rst.
- When undefined, the ports and counters do not exist. Core behaviour is identical in both builds.

## Test plan
- Load-use: idexMemRead=1, idexRd=5, ifidRs2=5. Required: exactly one cycle with pcWrite=0, ifidWrite=0, idexBubble=1. The next cycle, with idexMemRead=0, returns to normal flow.
- x0 exemption: idexMemRead=1, idexRd=0, ifidRs1=0. Required: no stall; pcWrite=1, idexBubble=0.
- Branch beats load-use: exBranchTaken=1 and luHaz=1 in the same cycle. Required: pcWrite=1, ifidFlush=1, idexBubble=1. With HAZARD_STATS_EN, flushCount increments by 1.
- Multi-cycle, MC_LATENCY=4: exMcStart pulse at cycle N. Required: freeze on cycles N..N+3, busy=1 on N+1..N+3, mcDone=1 only on N+3, normal flow at N+4. exBranchTaken pulsed at N+2 has no effect.
- MC_LATENCY=1 build: exMcStart pulse. Required: one freeze cycle with mcDone=1, busy never asserted.
- Reset mid-op: rst at cycle N+1 of a MC_LATENCY=4 op. Required: state is RUN after the edge, mcDone is never pulsed, and outputs take their reset values while rst=1.
